// File: rtl/artanh_pkg.sv
// Shared widths, Q-format shifts, coefficient table and state encoding for the
// artanh Horner evaluator.
package artanh_pkg;

  localparam int X_W    = 17;
  localparam int RES_W  = 32;
  localparam int ACC_W  = 34;
  localparam int COEF_W = 17;

  localparam int X2_SHIFT   = 30;
  localparam int FIN_SHIFT  = 17;
  localparam int COEF_SHIFT = 14;

  // c[k] = 1/(2k+1), unsigned Q1.16
  localparam logic [COEF_W-1:0] COEF_0 = 17'h10000;
  localparam logic [COEF_W-1:0] COEF_1 = 17'h05555;
  localparam logic [COEF_W-1:0] COEF_2 = 17'h03333;
  localparam logic [COEF_W-1:0] COEF_3 = 17'h02492;
  localparam logic [COEF_W-1:0] COEF_4 = 17'h01C72;
  localparam logic [COEF_W-1:0] COEF_5 = 17'h01746;
  localparam logic [COEF_W-1:0] COEF_6 = 17'h013B1;
  localparam logic [COEF_W-1:0] COEF_7 = 17'h01111;

  typedef enum logic [2:0] {
    IDLE,
    SQR,
    LOOP,
    FINAL,
    DONE
  } state_t;

  function automatic logic [COEF_W-1:0] coef_at(input logic [2:0] idx);
    logic [COEF_W-1:0] c;
    case (idx)
      3'd0:    c = COEF_0;
      3'd1:    c = COEF_1;
      3'd2:    c = COEF_2;
      3'd3:    c = COEF_3;
      3'd4:    c = COEF_4;
      3'd5:    c = COEF_5;
      3'd6:    c = COEF_6;
      default: c = COEF_7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/artanh_coef_rom.sv
// Combinational coefficient ROM: 3-bit term index to Q1.16 coefficient 1/(2k+1).
module artanh_coef_rom
  import artanh_pkg::*;
(
  input  logic [2:0]        addr,
  output logic [COEF_W-1:0] coef
);

  always_comb begin
    coef = coef_at(addr);
  end

endmodule

// File: rtl/artanh_maclaurin.sv
// artanh(x) by Horner evaluation of x*sum x^(2k)/(2k+1), one MAC per cycle.
// Define ARTANH_RANGE_CHECK_EN to reject |x| >= 0.75 with a saturated result and err.
//
// state | meaning
// IDLE  | waiting for start; latches x on accept
// SQR   | x2 = x*x, acc seeded with top coefficient
// LOOP  | acc = acc*x2 + c[k], k counting down to 0
// FINAL | result = acc*x in Q4.28
// DONE  | result ready; done pulses on the following cycle
module artanh_maclaurin
  import artanh_pkg::*;
#(
  parameter int TERMS = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [X_W-1:0]   data_x,
  output logic             done,
  output logic [RES_W-1:0] result,
  output logic             err
);

  localparam int         PROD_W = 2 * ACC_W;
  localparam int         FIN_W  = ACC_W + X_W;
  localparam logic [2:0] K_TOP  = 3'(TERMS - 1);

  state_t                  state_q, state_d;
  logic signed [X_W-1:0]   x_q, x_d;
  logic signed [ACC_W-1:0] x2_q, x2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]              k_q, k_d;
  logic [RES_W-1:0]        result_q, result_d;
  logic                    done_q, done_d;

  logic [COEF_W-1:0]        coef;
  logic [ACC_W-1:0]         coef_ext;
  logic signed [ACC_W-1:0]  sq_prod;
  logic signed [PROD_W-1:0] loop_prod, loop_shift;
  logic signed [FIN_W-1:0]  fin_prod, fin_shift;
  logic                     prod_unused;

  artanh_coef_rom u_coef_rom (
    .addr (k_q),
    .coef (coef)
  );

  // Q1.16 coefficient aligned to the Q3.30 accumulator
  assign coef_ext = {{(ACC_W - COEF_W - COEF_SHIFT){1'b0}}, coef, {COEF_SHIFT{1'b0}}};

  assign sq_prod    = ACC_W'(x_q) * ACC_W'(x_q);
  assign loop_prod  = PROD_W'(acc_q) * PROD_W'(x2_q);
  assign loop_shift = loop_prod >>> X2_SHIFT;
  assign fin_prod   = FIN_W'(acc_q) * FIN_W'(x_q);
  assign fin_shift  = fin_prod >>> FIN_SHIFT;

  // Bits above the kept window are intentionally dropped (no saturation).
  assign prod_unused = ^{loop_shift[PROD_W-1:ACC_W], fin_shift[FIN_W-1:RES_W]};

`ifdef ARTANH_RANGE_CHECK_EN
  logic err_q, err_d;
  logic out_of_range;

  assign out_of_range = ($signed(data_x) >= $signed(17'h06000)) ||
                        ($signed(data_x) <= $signed(17'h1A000));
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    x2_d     = x2_q;
    acc_d    = acc_q;
    k_d      = k_q;
    result_d = result_q;
    done_d   = (state_q == DONE);
`ifdef ARTANH_RANGE_CHECK_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = data_x;
          k_d     = K_TOP;
          state_d = SQR;
`ifdef ARTANH_RANGE_CHECK_EN
          err_d   = 1'b0;
          if (out_of_range) begin
            state_d  = DONE;
            err_d    = 1'b1;
            result_d = data_x[X_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          end
`endif
        end
      end
      SQR: begin
        x2_d    = sq_prod;
        acc_d   = coef_ext;
        k_d     = k_q - 3'd1;
        state_d = LOOP;
      end
      LOOP: begin
        acc_d = loop_shift[ACC_W-1:0] + coef_ext;
        k_d   = k_q - 3'd1;
        if (k_q == 3'd0) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        result_d = fin_shift[RES_W-1:0];
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      x2_q     <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef ARTANH_RANGE_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      x2_q     <= x2_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef ARTANH_RANGE_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign done   = done_q;
  assign result = result_q;

`ifdef ARTANH_RANGE_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_artanh_maclaurin.sv
// Directed bench for artanh_maclaurin: latency, hand-computed results, busy/held
// start, mid-run reset and (when ARTANH_RANGE_CHECK_EN is defined) range errors.
module tb_artanh_maclaurin;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] data_x;
  logic        done;
  logic [31:0] result;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  artanh_maclaurin #(.TERMS(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data_x (data_x),
    .done   (done),
    .result (result),
    .err    (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [16:0] x);
    @(negedge clk);
    data_x = x;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = edges after the sampling edge until done is seen; 0 if it never comes
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [16:0] x, input int exp_lat,
                        input bit chk_res, input logic [31:0] exp_res, input logic exp_err);
    int lat;
    start_op(x);
    wait_done(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_res) check_val({tag, "_res"}, result, exp_res);
    check_val({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    @(posedge clk);
    #1;
    check_val({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int first;
    int times[4];

    rst    = 1'b1;
    start  = 1'b0;
    data_x = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_done", {31'b0, done}, 32'd0);
    check_val("rst_res", result, 32'h0000_0000);
    check_val("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_done", {31'b0, done}, 32'd0);

    run_op("zero", 17'h00000, 10, 1'b1, 32'h0000_0000, 1'b0);
    run_op("pos_half", 17'h04000, 10, 1'b1, 32'h08C9_F3D6, 1'b0);
    run_op("neg_half", 17'h1C000, 10, 1'b1, 32'hF736_0C29, 1'b0);

    // busy: extra start pulses sampled at cycles 3 and 6 must be ignored
    @(negedge clk);
    data_x = 17'h02000;
    start  = 1'b1;
    n      = 0;
    first  = -1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      start = (c == 2 || c == 5);
      if (done) begin
        n++;
        if (first < 0) first = c;
      end
    end
    start = 1'b0;
    check_val("busy_count", 32'(n), 32'd1);
    check_val("busy_lat", 32'(first), 32'd10);
    check_val("quarter_res", result, 32'h0416_2BA8);

    // start held high: a result every 11 cycles
    @(negedge clk);
    data_x = 17'h04000;
    start  = 1'b1;
    n      = 0;
    for (int c = 0; c < 36; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (n < 4) times[n] = c;
        n++;
      end
    end
    start = 1'b0;
    check_val("held_count", 32'(n), 32'd3);
    check_val("held_first", 32'(times[0]), 32'd10);
    check_val("held_gap1", 32'(times[1] - times[0]), 32'd11);
    check_val("held_gap2", 32'(times[2] - times[1]), 32'd11);
    check_val("held_res", result, 32'h08C9_F3D6);
    repeat (16) @(posedge clk);
    #1;

    // reset sampled at cycle 5 of a run
    start_op(17'h04000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_done", {31'b0, done}, 32'd0);
    check_val("midrst_res", result, 32'h0000_0000);
    check_val("midrst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("midrst_next_done", {31'b0, done}, 32'd0);
    run_op("after_rst", 17'h1C000, 10, 1'b1, 32'hF736_0C29, 1'b0);

`ifdef ARTANH_RANGE_CHECK_EN
    run_op("range_pos", 17'h06000, 1, 1'b1, 32'h7FFF_FFFF, 1'b1);
    run_op("range_neg", 17'h1A000, 1, 1'b1, 32'h8000_0000, 1'b1);
    run_op("range_clear", 17'h04000, 10, 1'b1, 32'h08C9_F3D6, 1'b0);
`else
    run_op("norange", 17'h06000, 10, 1'b0, 32'h0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
